// File: rtl/dsp_wdata_channel_pkg.sv
// Shared helpers for the W-channel dispatcher slice.
// Holds default sizing and the pointer-width helper used by the FIFOs.
package dsp_wdata_channel_pkg;

  localparam int unsigned DEF_SLV_AMT          = 2;
  localparam int unsigned DEF_DATA_WIDTH       = 32;
  localparam int unsigned DEF_DSP_WDATA_DEPTH  = 16;
  localparam int unsigned DEF_DSP_WORDER_DEPTH = 4;

  // Index width for a power-of-two depth; never returns zero.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dsp_wdata_channel_fifo.sv
// First-word-fall-through FIFO with full/empty flags.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module dsp_wdata_channel_fifo
  import dsp_wdata_channel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = ptr_w(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dsp_wdata_channel.sv
// W-beat dispatcher for one master port: buffers beats and routes each burst
// to the slave chosen by the AW grant order, advancing on every WLAST pop.
module dsp_wdata_channel
  import dsp_wdata_channel_pkg::*;
#(
  parameter int SLV_AMT          = DEF_SLV_AMT,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int SLV_ID_W         = $clog2(SLV_AMT),
  parameter int DSP_WDATA_DEPTH  = DEF_DSP_WDATA_DEPTH,
  parameter int DSP_WORDER_DEPTH = DEF_DSP_WORDER_DEPTH
) (
  input  logic                          ACLK_i,
  input  logic                          ARESETn_i,
  input  logic [DATA_WIDTH-1:0]         m_WDATA_i,
  input  logic                          m_WLAST_i,
  input  logic                          m_WVALID_i,
  output logic                          m_WREADY_o,
  input  logic [SLV_ID_W-1:0]           dsp_AW_slv_id_i,
  input  logic                          dsp_AW_shift_en_i,
  output logic                          dsp_AW_order_full_o,
  output logic [DATA_WIDTH*SLV_AMT-1:0] sa_WDATA_o,
  output logic [SLV_AMT-1:0]            sa_WLAST_o,
  output logic [SLV_AMT-1:0]            sa_WVALID_o,
  input  logic [SLV_AMT-1:0]            sa_WREADY_i
);

  localparam int W_INFO_W = DATA_WIDTH + 1;

  logic [W_INFO_W-1:0]   wbuf_head;
  logic                  wbuf_full, wbuf_empty, wbuf_push, wbuf_pop;
  logic [SLV_ID_W-1:0]   order_head;
  logic                  order_full, order_empty, order_pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  eligible;
  logic [SLV_AMT-1:0]    sel;
  logic                  handshake;

  // No push-through: a full buffer refuses beats even while it is draining.
  assign m_WREADY_o = ~wbuf_full;
  assign wbuf_push  = m_WVALID_i & ~wbuf_full;

  dsp_wdata_channel_fifo #(
    .WIDTH (W_INFO_W),
    .DEPTH (DSP_WDATA_DEPTH)
  ) u_wbuf (
    .clk     (ACLK_i),
    .rst_n   (ARESETn_i),
    .push_i  (wbuf_push),
    .wdata_i ({m_WDATA_i, m_WLAST_i}),
    .pop_i   (wbuf_pop),
    .rdata_o (wbuf_head),
    .full_o  (wbuf_full),
    .empty_o (wbuf_empty)
  );

  dsp_wdata_channel_fifo #(
    .WIDTH (SLV_ID_W),
    .DEPTH (DSP_WORDER_DEPTH)
  ) u_order (
    .clk     (ACLK_i),
    .rst_n   (ARESETn_i),
    .push_i  (dsp_AW_shift_en_i),
    .wdata_i (dsp_AW_slv_id_i),
    .pop_i   (order_pop),
    .rdata_o (order_head),
    .full_o  (order_full),
    .empty_o (order_empty)
  );

  assign dsp_AW_order_full_o = order_full;

  assign head_data = wbuf_head[W_INFO_W-1:1];
  assign head_last = wbuf_head[0];
  assign eligible  = ~wbuf_empty & ~order_empty;

  // Demux: only the slice addressed by the order head carries the beat.
  genvar gi;
  generate
    for (gi = 0; gi < SLV_AMT; gi++) begin : g_slv
      assign sel[gi]         = eligible && (order_head == SLV_ID_W'(gi));
      assign sa_WVALID_o[gi] = sel[gi];
      assign sa_WLAST_o[gi]  = sel[gi] & head_last;
      assign sa_WDATA_o[DATA_WIDTH*gi +: DATA_WIDTH] =
        sel[gi] ? head_data : '0;
    end
  endgenerate

  assign handshake = |(sel & sa_WREADY_i);
  assign wbuf_pop  = handshake;
  assign order_pop = handshake & head_last;

endmodule

// File: tb/tb_dsp_wdata_channel.sv
// Scoreboard bench for dsp_wdata_channel: accepted beats queue their expected
// route, slave-side handshakes pop and compare.
module tb_dsp_wdata_channel;

  localparam int SLV = 2;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DW-1:0]     m_wdata;
  logic              m_wlast, m_wvalid;
  logic              m_wready;
  logic              aw_id;
  logic              aw_en;
  logic              order_full;
  logic [DW*SLV-1:0] sa_wdata;
  logic [SLV-1:0]    sa_wlast, sa_wvalid;
  logic [SLV-1:0]    s_ready;

  always #5 clk = ~clk;

  dsp_wdata_channel dut (
    .ACLK_i              (clk),
    .ARESETn_i           (rstn),
    .m_WDATA_i           (m_wdata),
    .m_WLAST_i           (m_wlast),
    .m_WVALID_i          (m_wvalid),
    .m_WREADY_o          (m_wready),
    .dsp_AW_slv_id_i     (aw_id),
    .dsp_AW_shift_en_i   (aw_en),
    .dsp_AW_order_full_o (order_full),
    .sa_WDATA_o          (sa_wdata),
    .sa_WLAST_o          (sa_wlast),
    .sa_WVALID_o         (sa_wvalid),
    .sa_WREADY_i         (s_ready)
  );

  typedef struct {
    int          slv;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t mq[$];
  beat_t sb[$];
  int    hs_cyc[$];
  int    cyc;
  int    n_checks;
  int    n_errors;
  int    n_acc;
  bit    saw_valid;
  int    push_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    if (mq.size() > 0) begin
      m_wvalid = 1'b1;
      m_wdata  = mq[0].data;
      m_wlast  = mq[0].last;
    end else begin
      m_wvalid = 1'b0;
      m_wdata  = '0;
      m_wlast  = 1'b0;
    end
  endtask

  task automatic monitor();
    logic  bad;
    beat_t e;
    bad = ($countones(sa_wvalid) > 1);
    for (int k = 0; k < SLV; k++)
      if (!sa_wvalid[k] && (sa_wdata[DW*k +: DW] != '0 || sa_wlast[k])) bad = 1'b1;
    chk("demux_onehot_zero", 64'(bad), 64'd0);
    if (sa_wvalid != '0) saw_valid = 1'b1;
    for (int k = 0; k < SLV; k++) begin
      if (sa_wvalid[k] && s_ready[k]) begin
        hs_cyc.push_back(cyc);
        chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("beat cyc=%0d slv=%0d data=0x%08h last=%0b", cyc, k, sa_wdata[DW*k +: DW], sa_wlast[k]);
          chk("route", 64'(k), 64'(e.slv));
          chk("wdata", 64'(sa_wdata[DW*k +: DW]), 64'(e.data));
          chk("wlast", 64'(sa_wlast[k]), 64'(e.last));
        end
      end
    end
    if (m_wvalid && m_wready) begin
      sb.push_back(mq.pop_front());
      n_acc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic send(input int slv, input logic [31:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.slv  = slv;
      b.data = base + 32'(i);
      b.last = (i == n - 1);
      mq.push_back(b);
    end
    drive();
  endtask

  task automatic aw_push(input int id);
    aw_id = 1'(id);
    aw_en = 1'b1;
    step();
    aw_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((sb.size() > 0 || mq.size() > 0) && c < budget) begin
      step();
      c++;
    end
    chk({tag, "_drained"}, 64'(sb.size() + mq.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wready"}, 64'(m_wready), 64'd1);
    chk({tag, "_order_full"}, 64'(order_full), 64'd0);
    chk({tag, "_wvalid"}, 64'(sa_wvalid), 64'd0);
    chk({tag, "_wdata"}, 64'(sa_wdata), 64'd0);
    chk({tag, "_wlast"}, 64'(sa_wlast), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_acc = 0; cyc = 0;
    rstn = 1'b0; aw_en = 1'b0; aw_id = 1'b0; s_ready = '0;
    m_wvalid = 1'b0; m_wdata = '0; m_wlast = 1'b0;
    step(); step();
    chk_reset_vals("rst");
    rstn = 1'b1;
    step();

    // AW first, then a 4-beat burst to slave 1.
    s_ready = 2'b11;
    hs_cyc.delete();
    aw_push(1);
    send(1, 32'hA0, 4);
    drain("t1", 20);
    chk("t1_beats", 64'(hs_cyc.size()), 64'd4);
    if (hs_cyc.size() > 0) chk("t1_span", 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 64'd3);

    // W before AW: held until the order entry exists.
    hs_cyc.delete();
    saw_valid = 1'b0;
    send(0, 32'hC0, 2);
    repeat (5) step();
    chk("t2_accepted", 64'(mq.size()), 64'd0);
    chk("t2_held_no_valid", 64'(saw_valid), 64'd0);
    push_cyc = cyc;
    aw_push(0);
    drain("t2", 20);
    chk("t2_beats", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() > 0) chk("t2_start", 64'(hs_cyc[0]), 64'(push_cyc + 1));

    // Back-to-back bursts 0 / 1,1,1 / 0,0 with no bubble.
    hs_cyc.delete();
    aw_push(0); aw_push(1); aw_push(0);
    send(0, 32'h10, 1);
    send(1, 32'h20, 3);
    send(0, 32'h30, 2);
    drain("t3", 30);
    chk("t3_beats", 64'(hs_cyc.size()), 64'd6);
    if (hs_cyc.size() > 0) chk("t3_span", 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 64'd5);

    // Back-pressure: 17-beat burst against a stalled slave.
    s_ready = 2'b00;
    aw_push(1);
    n_acc = 0;
    send(1, 32'hB0, 17);
    repeat (20) step();
    chk("t4_accepted", 64'(n_acc), 64'd16);
    chk("t4_wready_low", 64'(m_wready), 64'd0);
    chk("t4_held_valid", 64'(sa_wvalid), 64'h2);
    chk("t4_held_data", 64'(sa_wdata[DW +: DW]), 64'hB0);
    repeat (3) step();
    chk("t4_stable_valid", 64'(sa_wvalid), 64'h2);
    chk("t4_stable_data", 64'(sa_wdata[DW +: DW]), 64'hB0);
    s_ready = 2'b11;
    drain("t4", 40);

    // Order queue full; the fifth push is dropped.
    aw_push(1); aw_push(0); aw_push(1); aw_push(0);
    chk("t5_full", 64'(order_full), 64'd1);
    aw_push(1);
    chk("t5_still_full", 64'(order_full), 64'd1);
    send(1, 32'h50, 1);
    send(0, 32'h51, 1);
    send(1, 32'h52, 1);
    send(0, 32'h53, 1);
    drain("t5", 30);
    chk("t5_not_full", 64'(order_full), 64'd0);
    saw_valid = 1'b0;
    send(1, 32'h5F, 1);
    repeat (6) step();
    chk("t5_extra_accepted", 64'(mq.size()), 64'd0);
    chk("t5_dropped_push", 64'(saw_valid), 64'd0);

    // Reset after beat 2 of 4; stale beats and order entries vanish.
    s_ready = 2'b00;
    aw_push(0);
    send(0, 32'h60, 4);
    step(); step();
    mq.delete();
    drive();
    sb.delete();
    rstn = 1'b0;
    step();
    chk_reset_vals("t6_rst");
    rstn = 1'b1;
    s_ready = 2'b11;
    saw_valid = 1'b0;
    hs_cyc.delete();
    repeat (5) step();
    chk("t6_no_stale", 64'(saw_valid), 64'd0);
    aw_push(1);
    send(1, 32'h70, 2);
    drain("t6", 20);
    chk("t6_beats", 64'(hs_cyc.size()), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
